// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the fetch stage's control inputs, instruction-cache
// handshake and IF/ID outputs into one bundle.
// Ports: none (signal container); master = fetch stage side, slave = environment side.
interface fetch_stage_if;
    // control from decode / execute
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exception;
    // instruction cache handshake
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_data;
    // IF/ID register towards decode
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;
    logic        fetch_misaligned;

    modport master (
        input  stall, redirect, redirect_pc, exception,
        input  icache_ready, icache_data,
        output icache_req, icache_addr,
        output instruction, pc_out, valid, fetch_misaligned
    );

    modport slave (
        output stall, redirect, redirect_pc, exception,
        output icache_ready, icache_data,
        input  icache_req, icache_addr,
        input  instruction, pc_out, valid, fetch_misaligned
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, fetches from the instruction cache and drives the IF/ID register.
// Latency: a cache hit reaches decode one edge later; back-to-back hits give 1 instr/cycle.
// Backpressure: stall parks one fetched word in a one-entry buffer and stops requesting.
// Ports: clk, reset (sync, active-high); bus (fetch_stage_if.master) carries
//        stall/redirect/exception, the icache req/ready handshake and the IF/ID outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter logic [31:0] EXC_PC   = 32'h0000_2000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    // REQ: requesting bus.icache_addr = pc. FULL: buffer occupied, no request.
    typedef enum logic {
        S_REQ  = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        misaligned_q, misaligned_d;

    logic        flush;
    logic        bad_target;

    assign flush      = bus.exception | bus.redirect;
    // A misaligned redirect is turned into a trap-vector fetch; an exception
    // in the same cycle wins and suppresses the misaligned report.
    assign bad_target = bus.redirect & ~bus.exception & (bus.redirect_pc[1:0] != 2'b00);

    // Request is gated by reset so the cache never sees a request while the
    // stage is being reinitialised.
    assign bus.icache_req       = (state_q == S_REQ) & ~reset;
    assign bus.icache_addr      = pc_q;
    assign bus.instruction      = instr_q;
    assign bus.pc_out           = pc_out_q;
    assign bus.valid            = valid_q;
    assign bus.fetch_misaligned = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            buf_instr_q  <= NOP;
            buf_pc_q     <= 32'h0;
            instr_q      <= NOP;
            pc_out_q     <= 32'h0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        misaligned_d = 1'b0;

        if (flush) begin
            // Flush overrides stall: any response this cycle and any buffered
            // word are dropped (returning to REQ makes the buffer dead).
            state_d      = S_REQ;
            valid_d      = 1'b0;
            instr_d      = NOP;
            pc_d         = (bus.exception | bad_target) ? EXC_PC : bus.redirect_pc;
            misaligned_d = bad_target;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.icache_ready) begin
                        pc_d = pc_q + 32'd4;
                        if (!bus.stall) begin
                            instr_d  = bus.icache_data;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                        end else begin
                            // Decode is stalled: park the word, IF/ID holds.
                            buf_instr_d = bus.icache_data;
                            buf_pc_d    = pc_q;
                            state_d     = S_FULL;
                        end
                    end else if (!bus.stall) begin
                        // Miss wait cycle: hand decode a bubble, keep pc_out.
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (!bus.stall) begin
                        instr_d  = buf_instr_q;
                        pc_out_d = buf_pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

endmodule
